mac_dot_pipe: RTL and testbench



---
 rtl/mac_dot_pipe.sv | 238 +++++++++++++++++++++++
 tb/tb_mac_dot_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_pipe.sv
// mac_dot_pipe: three-stage pipelined LANES-wide dot-product MAC with valid/ready handshakes.
// Optional build macro MAC_DOT_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module mac_dot_pipe #(
    parameter int LANES  = 4,
    parameter int DW     = 8,
    parameter int ACC_W  = 32,
    parameter int CNT_W  = 16,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic [ACC_W-1:0]      sum_in,
    input  logic [LANES*DW-1:0]   a,
    input  logic [LANES*DW-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_sum,
    output logic                  out_ovf,
    output logic [CNT_W-1:0]      out_count
);

    localparam int PW = 2 * DW;
    localparam int LW = $clog2(LANES);
    localparam int TW = PW + LW;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [PW-1:0] lane_mul(input logic [DW-1:0] x, input logic [DW-1:0] y);
        logic signed [PW-1:0] sx;
        logic signed [PW-1:0] sy;
        logic [PW-1:0]        ux;
        logic [PW-1:0]        uy;
        sx = PW'(signed'(x));
        sy = PW'(signed'(y));
        ux = PW'(x);
        uy = PW'(y);
        if (SIGNED != 0) return PW'(sx * sy);
        else             return PW'(ux * uy);
    endfunction

    function automatic logic [TW-1:0] ext_prod(input logic [PW-1:0] p);
        if (SIGNED != 0) return TW'(signed'(p));
        else             return TW'(p);
    endfunction

    function automatic logic [ACC_W-1:0] ext_tree(input logic [TW-1:0] t);
        if (SIGNED != 0) return ACC_W'(signed'(t));
        else             return ACC_W'(t);
    endfunction

    logic stall;
    logic accept;

    logic             first_q,    first_d;
    logic             s1_valid_q, s1_valid_d;
    logic             s1_last_q,  s1_last_d;
    logic             s1_first_q, s1_first_d;
    logic [ACC_W-1:0] s1_sum_q,   s1_sum_d;
    logic [PW-1:0]    s1_prod_q [LANES];
    logic [PW-1:0]    s1_prod_d [LANES];

    logic             s2_valid_q, s2_valid_d;
    logic             s2_last_q,  s2_last_d;
    logic             s2_first_q, s2_first_d;
    logic [ACC_W-1:0] s2_sum_q,   s2_sum_d;
    logic [ACC_W-1:0] s2_tree_q,  s2_tree_d;

    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             ovf_q,       ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [ACC_W-1:0] out_sum_q,   out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_ovf_q,   out_ovf_d;

    logic [TW-1:0]    tree_sum;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   raw_sum;
    logic             add_ovf;
    logic             sticky_prev;
    logic [ACC_W-1:0] result;
    logic [CNT_W-1:0] cnt_next;

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & ~stall;

    // S1: lane products plus the per-beat control that travels alongside them.
    always_comb begin
        first_d    = first_q;
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_first_d = s1_first_q;
        s1_sum_d   = s1_sum_q;
        for (int i = 0; i < LANES; i++) s1_prod_d[i] = s1_prod_q[i];
        if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                first_d    = in_last;
                s1_last_d  = in_last;
                s1_first_d = first_q;
                s1_sum_d   = sum_in;
                for (int i = 0; i < LANES; i++)
                    s1_prod_d[i] = lane_mul(a[i*DW +: DW], b[i*DW +: DW]);
            end
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LANES; i++) tree_sum = tree_sum + ext_prod(s1_prod_q[i]);
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        s2_first_d = s2_first_q;
        s2_sum_d   = s2_sum_q;
        s2_tree_d  = s2_tree_q;
        if (!stall) begin
            s2_valid_d = s1_valid_q;
            s2_last_d  = s1_last_q;
            s2_first_d = s1_first_q;
            s2_sum_d   = s1_sum_q;
            s2_tree_d  = ext_tree(tree_sum);
        end
    end

    // S3 adder: the first beat of a vector replaces the running sum with the seed.
    always_comb begin
        base        = s2_first_q ? s2_sum_q : acc_q;
        raw_sum     = {1'b0, base} + {1'b0, s2_tree_q};
        sticky_prev = s2_first_q ? 1'b0 : ovf_q;
        if (SIGNED != 0)
            add_ovf = (base[ACC_W-1] == s2_tree_q[ACC_W-1]) &&
                      (raw_sum[ACC_W-1] != base[ACC_W-1]);
        else
            add_ovf = raw_sum[ACC_W];
`ifdef MAC_DOT_SATURATE_EN
        // Once clamped, the accumulator already holds the clamp value; keep it.
        if (sticky_prev)
            result = acc_q;
        else if (add_ovf) begin
            if (SIGNED == 0)
                result = '1;
            else if (base[ACC_W-1])
                result = {1'b1, {(ACC_W-1){1'b0}}};
            else
                result = {1'b0, {(ACC_W-1){1'b1}}};
        end else
            result = raw_sum[ACC_W-1:0];
`else
        result = raw_sum[ACC_W-1:0];
`endif
        if (s2_first_q)
            cnt_next = CNT_W'(1);
        else if (cnt_q == CNT_MAX)
            cnt_next = cnt_q;
        else
            cnt_next = cnt_q + CNT_W'(1);
    end

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (!stall && s2_valid_q) begin
            if (s2_last_q) begin
                out_sum_d   = result;
                out_count_d = cnt_next;
                out_ovf_d   = sticky_prev | add_ovf;
                out_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
            end else begin
                acc_d = result;
                cnt_d = cnt_next;
                ovf_d = sticky_prev | add_ovf;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q     <= 1'b1;
            s1_valid_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_sum_q    <= '0;
            for (int i = 0; i < LANES; i++) s1_prod_q[i] <= '0;
            s2_valid_q  <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_sum_q    <= '0;
            s2_tree_q   <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            first_q     <= first_d;
            s1_valid_q  <= s1_valid_d;
            s1_last_q   <= s1_last_d;
            s1_first_q  <= s1_first_d;
            s1_sum_q    <= s1_sum_d;
            for (int i = 0; i < LANES; i++) s1_prod_q[i] <= s1_prod_d[i];
            s2_valid_q  <= s2_valid_d;
            s2_last_q   <= s2_last_d;
            s2_first_q  <= s2_first_d;
            s2_sum_q    <= s2_sum_d;
            s2_tree_q   <= s2_tree_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_dot_pipe.sv
// tb_mac_dot_pipe: directed bench driving an unsigned and a signed mac_dot_pipe in lockstep.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_mac_dot_pipe;

    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int ACC_W = 32;
    localparam int CNT_W = 16;

`ifdef MAC_DOT_SATURATE_EN
    localparam logic [31:0] OVF_SUM   = 32'hFFFF_FFFF;
    localparam logic [31:0] STICKY_SUM = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] OVF_SUM   = 32'h0003_F7F4;
    localparam logic [31:0] STICKY_SUM = 32'h0003_F7FE;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_last;
    logic [ACC_W-1:0]    sum_in;
    logic [LANES*DW-1:0] a;
    logic [LANES*DW-1:0] b;
    logic                out_ready;

    logic                in_ready_u,  in_ready_s;
    logic                out_valid_u, out_valid_s;
    logic [ACC_W-1:0]    out_sum_u,   out_sum_s;
    logic                out_ovf_u,   out_ovf_s;
    logic [CNT_W-1:0]    out_count_u, out_count_s;

    int vectors     = 0;
    int miscompares = 0;
    int cyc;

    always #5 clk = ~clk;

    mac_dot_pipe #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W), .CNT_W(CNT_W), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u), .in_last(in_last),
        .sum_in(sum_in), .a(a), .b(b), .out_valid(out_valid_u), .out_ready(out_ready),
        .out_sum(out_sum_u), .out_ovf(out_ovf_u), .out_count(out_count_u)
    );

    mac_dot_pipe #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W), .CNT_W(CNT_W), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_last(in_last),
        .sum_in(sum_in), .a(a), .b(b), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_sum(out_sum_s), .out_ovf(out_ovf_s), .out_count(out_count_s)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
            $error("[TB] miscompare on %s", tag);
        end
    endtask

    // Presents one beat and returns on the falling edge after it was accepted.
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                                 input logic [31:0] sv, input logic lastv);
        int waits;
        waits    = 0;
        a        = av;
        b        = bv;
        sum_in   = sv;
        in_last  = lastv;
        in_valid = 1'b1;
        while (!in_ready_u && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        checkVal("accept_bound", 32'(waits < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        while (!out_valid_u && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkVal("valid_bound", 32'(out_valid_u), 32'd1);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] expSum, input logic [31:0] expCnt,
                               input logic expOvf, input logic [31:0] expSumS, input logic expOvfS);
        checkVal({tag, "_sum_u"},   out_sum_u,           expSum);
        checkVal({tag, "_count_u"}, 32'(out_count_u),    expCnt);
        checkVal({tag, "_ovf_u"},   32'(out_ovf_u),      32'(expOvf));
        checkVal({tag, "_valid_s"}, 32'(out_valid_s),    32'd1);
        checkVal({tag, "_sum_s"},   out_sum_s,           expSumS);
        checkVal({tag, "_count_s"}, 32'(out_count_s),    expCnt);
        checkVal({tag, "_ovf_s"},   32'(out_ovf_s),      32'(expOvfS));
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        sum_in    = '0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        checkVal("rst_valid", 32'(out_valid_u), 32'd0);
        checkVal("rst_sum",   out_sum_u,        32'd0);
        checkVal("rst_count", 32'(out_count_u), 32'd0);
        checkVal("rst_ovf",   32'(out_ovf_u),   32'd0);
        checkVal("rst_ready", 32'(in_ready_u),  32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single beat: dot = 1+2+3+4 = 10, plus seed 10
        applyStimulus(32'h0403_0201, 32'h0101_0101, 32'd10, 1'b1);
        waitValid(cyc);
        checkVal("t1_latency", 32'(cyc), 32'd2);
        checkOutput("t1", 32'd20, 32'd1, 1'b0, 32'd20, 1'b0);
        @(negedge clk);
        checkVal("t1_clear", 32'(out_valid_u), 32'd0);

        // Three back-to-back beats; later seeds must be ignored
        applyStimulus(32'h0403_0201, 32'h0101_0101, 32'd5,   1'b0);
        applyStimulus(32'h0403_0201, 32'h0101_0101, 32'd999, 1'b0);
        applyStimulus(32'h0403_0201, 32'h0101_0101, 32'd999, 1'b1);
        waitValid(cyc);
        checkVal("t2_latency", 32'(cyc), 32'd2);
        checkOutput("t2", 32'd35, 32'd3, 1'b0, 32'd35, 1'b0);
        @(negedge clk);

        // Backpressure: two single-beat vectors with the consumer stalled
        out_ready = 1'b0;
        applyStimulus(32'h0403_0201, 32'h0101_0101, 32'd10, 1'b1);
        applyStimulus(32'h0403_0201, 32'h0101_0101, 32'd20, 1'b1);
        waitValid(cyc);
        checkVal("t3_ready_low", 32'(in_ready_u), 32'd0);
        checkVal("t3_ready_low_s", 32'(in_ready_s), 32'd0);
        checkOutput("t3a", 32'd20, 32'd1, 1'b0, 32'd20, 1'b0);
        a        = 32'hFFFF_FFFF;
        b        = 32'hFFFF_FFFF;
        sum_in   = 32'd0;
        in_last  = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        checkVal("t3_hold_valid", 32'(out_valid_u), 32'd1);
        checkVal("t3_hold_sum",   out_sum_u,        32'd20);
        checkVal("t3_hold_ready", 32'(in_ready_u),  32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkVal("t3b_valid", 32'(out_valid_u), 32'd1);
        checkOutput("t3b", 32'd30, 32'd1, 1'b0, 32'd30, 1'b0);
        @(negedge clk);
        checkVal("t3_clear", 32'(out_valid_u), 32'd0);
        repeat (4) @(negedge clk);
        checkVal("t3_no_extra", 32'(out_valid_u), 32'd0);

        // Overflow: unsigned dot 260100 on top of 0xFFFFFFF0; signed dot is +4
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b1);
        waitValid(cyc);
        checkOutput("t4", OVF_SUM, 32'd1, 1'b1, 32'hFFFF_FFF4, 1'b0);
        @(negedge clk);

        // Overflow stays sticky across the remaining beats of the vector
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF0, 1'b0);
        applyStimulus(32'h0403_0201, 32'h0101_0101, 32'd0,         1'b1);
        waitValid(cyc);
        checkOutput("t4b", STICKY_SUM, 32'd2, 1'b1, 32'hFFFF_FFFE, 1'b0);
        @(negedge clk);

        // Signed lane: -1 * 2 = -2 (unsigned view: 255*2 = 510)
        applyStimulus(32'h0000_00FF, 32'h0000_0002, 32'd0, 1'b1);
        waitValid(cyc);
        checkOutput("t5", 32'd510, 32'd1, 1'b0, 32'hFFFF_FFFE, 1'b0);
        @(negedge clk);

        // Reset mid-vector discards the partial sum
        applyStimulus(32'h0403_0201, 32'h0101_0101, 32'd100, 1'b0);
        applyStimulus(32'h0403_0201, 32'h0101_0101, 32'd100, 1'b0);
        rst = 1'b1;
        #1;
        checkVal("t6_rst_valid", 32'(out_valid_u), 32'd0);
        @(negedge clk);
        checkVal("t6_rst_valid2", 32'(out_valid_u), 32'd0);
        checkVal("t6_rst_valid_s", 32'(out_valid_s), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(32'h0403_0201, 32'h0101_0101, 32'd0, 1'b1);
        waitValid(cyc);
        checkVal("t6_latency", 32'(cyc), 32'd2);
        checkOutput("t6", 32'd10, 32'd1, 1'b0, 32'd10, 1'b0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
